multi_phase_traffic_controller: RTL and testbench
=================================================

// Module: multi_phase_traffic_controller
// PURPOSE
//  Parametrised N-approach intersection controller: round-robin vehicle phases, per-phase
//  sensor-driven skip/extension, all-red clearance, per-phase latched pedestrian walk.
//  Sits after the sync/debounce front end, which delivers clean inputs. Drives light decoders.
//  Replaces the fixed main/side controller with programmable timing from a config register block.
// PARAMETERS
//  NUM_PHASES  4      vehicle phases (2..8); phase 0 is the rest (default) phase
//  TIMER_W     8      width of every timing input and of the internal tick counter
//  TICK_DIV    50_000_000  clk cycles per timing tick (prescaler); sim uses 4
// PORTS
//  clk          in   1            system clock
//  reset        in   1            reset is asynchronous and active-low (0 = reset)
//  sensor       in   NUM_PHASES   vehicle demand per phase, synchronised, level
//  walk_req     in   NUM_PHASES   walk button per phase, debounced, 1-cycle or level
//  t_green_min  in   TIMER_W      base green, ticks
//  t_green_ext  in   TIMER_W      single extension, ticks (0 = no extension)
//  t_yellow     in   TIMER_W      yellow, ticks
//  t_allred     in   TIMER_W      all-red clearance, ticks
//  t_walk       in   TIMER_W      walk interval, ticks
//  preempt      in   1            emergency request (used only with PREEMPT_EN)
//  preempt_ph   in   $clog2(NUM_PHASES)  phase to force green (PREEMPT_EN only)
//  green/yellow/red out NUM_PHASES  one-hot lamp drives; exactly one lamp per phase lit
//  walk         out  NUM_PHASES   walk lamp per phase
//  cur_phase    out  $clog2(NUM_PHASES) phase owning green/yellow
//  state        out  3            FSM state code (debug)
// BEHAVIOUR
//  - Reset (async): state=ALL_RED, red=all 1, green=yellow=walk=0, cur_phase=0, next=0,
//    pending walk=0, prescaler=0, timer loaded with t_allred on first clk after release.
//  - Tick: prescaler wraps at TICK_DIV-1, pulses tick 1 cycle; timer decrements on tick only.
//    Timer loaded on every state entry; expired = (timer==1 && tick). Time value 0 treated as 1.
//  - States: ALL_RED -> WALK (if any pending) else GREEN; WALK -> GREEN; GREEN -> EXT or YELLOW;
//    EXT -> YELLOW; YELLOW -> ALL_RED. Transitions occur the cycle after expired; outputs registered.
//  - GREEN expiry: go EXT iff sensor[cur] high and t_green_ext!=0; extension granted once per green.
//  - Next-phase select at YELLOW entry: first p after cur (modulo N) with sensor[p] or pending
//    walk[p]; none -> phase 0; if cur is only demand and cur!=0 -> phase 0.
//    Exception: if cur==0 and no demand anywhere, GREEN(0) restarts timer (rest, no yellow).
//  - Walk: walk_req[p] sets pend[p] any cycle. WALK state: walk[p]=pend[p] for all p, all
//    vehicle red; pend bits cleared at WALK entry. Request arriving during WALK pends for next cycle.
//  - Simultaneous set/clear of pend[p] on WALK entry: set wins (stays pending).
//  - Lamps: GREEN/EXT -> green[cur]; YELLOW -> yellow[cur]; all other phases red always.
//  - Timing inputs sampled only at state entry; mid-interval changes take effect next state.
// CONFIGURATION
//  PREEMPT_EN defined: preempt high in GREEN/EXT of phase != preempt_ph -> YELLOW next cycle
//    (timer reload), next=preempt_ph; in ALL_RED/WALK -> next=preempt_ph, WALK skipped (pends kept).
//    While preempt high, GREEN(preempt_ph) holds (timer frozen); release -> normal expiry.
//  PREEMPT_EN undefined: preempt/preempt_ph ports present but ignored; no preempt logic.
// STRUCTURE
//  Shared package traffic_pkg: state enum codes (ALL_RED=0,WALK=1,GREEN=2,EXT=3,YELLOW=4),
//    default timing constants, phase-index width function.
//  One sub-module: tick_timer (prescaler + loadable down-counter, outputs tick, expired).
// TESTING (TICK_DIV=4, N=4, min=3 ext=2 yel=2 allred=1 walk=2)
//  1 Reset low mid-GREEN -> same cycle red=4'b1111, green=0, state=ALL_RED, cur_phase=0.
//  2 No sensors -> green[0] held indefinitely, never yellow; walk=0.
//  3 sensor=4'b0100 from reset -> green0 3 ticks, yellow0 2, allred 1, green[2]; phases 1,3 skipped.
//  4 sensor[cur] held at base expiry -> green lasts 5 ticks total, then yellow (one extension only).
//  5 walk_req[1] pulse during GREEN(0) -> after ALL_RED, WALK 2 ticks walk=4'b0010, then green[1].
//  6 PREEMPT_EN: preempt=1,preempt_ph=3 in GREEN(1) -> yellow1 next cycle, allred, green[3] held
//    until preempt=0; without macro same stimulus -> normal sequence unchanged.

Source files
------------

// File: rtl/multi_phase_traffic_controller_pkg.sv
// ============================================================================
// Package     : traffic_pkg
// Description : Shared types and constants for the multi-phase intersection
//               controller: FSM state codes, default timing values and the
//               phase-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package traffic_pkg;

  // FSM state codes; also driven on the debug state output
  typedef enum logic [2:0] {
    ALL_RED = 3'd0,
    WALK    = 3'd1,
    GREEN   = 3'd2,
    EXT     = 3'd3,
    YELLOW  = 3'd4
  } state_e;

  // Power-on defaults for the configuration register block, in ticks
  localparam int DEF_T_GREEN_MIN = 30;
  localparam int DEF_T_GREEN_EXT = 10;
  localparam int DEF_T_YELLOW    = 4;
  localparam int DEF_T_ALLRED    = 2;
  localparam int DEF_T_WALK      = 8;

  // Bits needed to index a phase; never less than one bit
  function automatic int phase_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multi_phase_traffic_controller_tick_timer.sv
// ============================================================================
// Module      : tick_timer
// Description : Free-running prescaler producing a one-cycle tick every
//               TICK_DIV clocks, plus a loadable down-counter that counts
//               ticks. A load value of 0 is treated as 1. expired pulses on
//               the tick that takes the counter from 1 to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_timer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int TIMER_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               hold,
  output logic               tick,
  output logic               expired
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  assign tick    = (presc_q == PRE_W'(TICK_DIV - 1));
  assign expired = tick && !hold && (timer_q == TIMER_W'(1));

  // Next prescaler and counter values; a load overrides any decrement
  always_comb begin
    presc_d = tick ? '0 : presc_q + 1'b1;
    timer_d = timer_q;
    if (load) begin
      timer_d = (load_val == '0) ? TIMER_W'(1) : load_val;
    end else if (tick && !hold && (timer_q != '0)) begin
      timer_d = timer_q - 1'b1;
    end
  end

  // Prescaler and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      timer_q <= '0;
    end else begin
      presc_q <= presc_d;
      timer_q <= timer_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/multi_phase_traffic_controller.sv
// ============================================================================
// Module      : multi_phase_traffic_controller
// Description : N-approach intersection controller. Round-robin vehicle
//               phases with sensor-driven skip and a single green extension,
//               all-red clearance between phases and latched per-phase
//               pedestrian walk. Phase 0 is the rest phase.
//               Optional feature macro: PREEMPT_EN (emergency preemption).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_phase_traffic_controller
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int TIMER_W    = 8,
  parameter int TICK_DIV   = 50_000_000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_PHASES-1:0]               sensor,
  input  logic [NUM_PHASES-1:0]               walk_req,
  input  logic [TIMER_W-1:0]                  t_green_min,
  input  logic [TIMER_W-1:0]                  t_green_ext,
  input  logic [TIMER_W-1:0]                  t_yellow,
  input  logic [TIMER_W-1:0]                  t_allred,
  input  logic [TIMER_W-1:0]                  t_walk,
  input  logic                                preempt,
  input  logic [phase_w(NUM_PHASES)-1:0]      preempt_ph,
  output logic [NUM_PHASES-1:0]               green,
  output logic [NUM_PHASES-1:0]               yellow,
  output logic [NUM_PHASES-1:0]               red,
  output logic [NUM_PHASES-1:0]               walk,
  output logic [phase_w(NUM_PHASES)-1:0]      cur_phase,
  output logic [2:0]                          state
);

  localparam int PH_W = phase_w(NUM_PHASES);

  state_e                state_q, state_d;
  logic [PH_W-1:0]       cur_q, cur_d;
  logic [PH_W-1:0]       next_q, next_d;
  logic [NUM_PHASES-1:0] pend_q, pend_d;
  logic                  start_q, start_d;
  logic [NUM_PHASES-1:0] green_q, green_d;
  logic [NUM_PHASES-1:0] yellow_q, yellow_d;
  logic [NUM_PHASES-1:0] red_q, red_d;
  logic [NUM_PHASES-1:0] walk_q, walk_d;

  logic                  w_load;
  logic [TIMER_W-1:0]    w_load_val;
  logic                  w_hold;
  logic                  w_tick;
  logic                  w_expired;
  logic [NUM_PHASES-1:0] w_dem;
  logic                  w_any_demand;
  logic [PH_W-1:0]       w_sel;
  logic                  w_found;
  int                    w_idx;

  tick_timer #(
    .TICK_DIV (TICK_DIV),
    .TIMER_W  (TIMER_W)
  ) u_tick_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (w_load_val),
    .hold     (w_hold),
    .tick     (w_tick),
    .expired  (w_expired)
  );

  assign w_dem        = sensor | pend_q;
  assign w_any_demand = |w_dem;

  // Next phase: first demanding phase after cur (wrapping); falls back to
  // phase 0 when nothing else wants service
  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int i = 1; i <= NUM_PHASES; i++) begin
      w_idx = int'(cur_q) + i;
      if (w_idx >= NUM_PHASES) w_idx = w_idx - NUM_PHASES;
      if (!w_found && w_dem[PH_W'(w_idx)]) begin
        w_found = 1'b1;
        if (w_idx != int'(cur_q)) w_sel = PH_W'(w_idx);
      end
    end
  end

`ifndef PREEMPT_EN
  logic w_unused_preempt;
  assign w_unused_preempt = ^{preempt, preempt_ph, w_tick};
`else
  logic w_unused_tick;
  assign w_unused_tick = w_tick;
`endif

  // Phase sequencing, timer loads and registered lamp values
  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    next_d     = next_q;
    pend_d     = pend_q | walk_req;
    start_d    = 1'b0;
    w_load     = 1'b0;
    w_load_val = t_allred;
    w_hold     = 1'b0;

    if (start_q) begin
      // First clock after reset release arms the initial clearance
      w_load     = 1'b1;
      w_load_val = t_allred;
    end else begin
      case (state_q)
        ALL_RED: if (w_expired) begin
          w_load = 1'b1;
          if (|pend_q) begin
            state_d    = WALK;
            w_load_val = t_walk;
            pend_d     = walk_req;   // a request this cycle stays pending
          end else begin
            state_d    = GREEN;
            cur_d      = next_q;
            w_load_val = t_green_min;
          end
        end
        WALK: if (w_expired) begin
          state_d    = GREEN;
          cur_d      = next_q;
          w_load     = 1'b1;
          w_load_val = t_green_min;
        end
        GREEN: if (w_expired) begin
          w_load = 1'b1;
          if (sensor[cur_q] && (t_green_ext != '0)) begin
            state_d    = EXT;
            w_load_val = t_green_ext;
          end else if ((cur_q == '0) && !w_any_demand) begin
            w_load_val = t_green_min;  // rest in phase 0 without yellow
          end else begin
            state_d    = YELLOW;
            w_load_val = t_yellow;
            next_d     = w_sel;
          end
        end
        EXT: if (w_expired) begin
          state_d    = YELLOW;
          w_load     = 1'b1;
          w_load_val = t_yellow;
          next_d     = w_sel;
        end
        YELLOW: if (w_expired) begin
          state_d    = ALL_RED;
          w_load     = 1'b1;
          w_load_val = t_allred;
        end
        default: begin
          state_d    = ALL_RED;
          w_load     = 1'b1;
          w_load_val = t_allred;
        end
      endcase

`ifdef PREEMPT_EN
      if (preempt) begin
        case (state_q)
          GREEN, EXT: begin
            if (cur_q != preempt_ph) begin
              state_d    = YELLOW;
              w_load     = 1'b1;
              w_load_val = t_yellow;
              next_d     = preempt_ph;
            end else begin
              // Preempted phase holds green with the timer frozen
              state_d = state_q;
              w_load  = 1'b0;
              w_hold  = 1'b1;
              next_d  = next_q;
            end
          end
          ALL_RED: begin
            next_d = preempt_ph;
            if (w_expired) begin
              state_d    = GREEN;
              cur_d      = preempt_ph;
              w_load     = 1'b1;
              w_load_val = t_green_min;
              pend_d     = pend_q | walk_req;
            end
          end
          WALK: begin
            state_d    = GREEN;
            cur_d      = preempt_ph;
            next_d     = preempt_ph;
            w_load     = 1'b1;
            w_load_val = t_green_min;
          end
          YELLOW: next_d = preempt_ph;
          default: ;
        endcase
      end
`endif
    end

    green_d  = ((state_d == GREEN) || (state_d == EXT)) ?
               (NUM_PHASES'(1) << cur_d) : '0;
    yellow_d = (state_d == YELLOW) ? (NUM_PHASES'(1) << cur_d) : '0;
    red_d    = ~(green_d | yellow_d);
    if (state_d == WALK) begin
      walk_d = (state_q == WALK) ? walk_q : pend_q;
    end else begin
      walk_d = '0;
    end
  end

  // Controller state and lamp registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ALL_RED;
      cur_q    <= '0;
      next_q   <= '0;
      pend_q   <= '0;
      start_q  <= 1'b1;
      green_q  <= '0;
      yellow_q <= '0;
      red_q    <= '1;
      walk_q   <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      next_q   <= next_d;
      pend_q   <= pend_d;
      start_q  <= start_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      red_q    <= red_d;
      walk_q   <= walk_d;
    end
  end

  assign green     = green_q;
  assign yellow    = yellow_q;
  assign red       = red_q;
  assign walk      = walk_q;
  assign cur_phase = cur_q;
  assign state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_phase_traffic_controller.sv
// ============================================================================
// Module      : tb_multi_phase_traffic_controller
// Description : Directed self-checking bench, N=4, TICK_DIV=4 (one tick =
//               4 clocks), min=3 ext=2 yel=2 allred=1 walk=2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_phase_traffic_controller;

  localparam logic [2:0] S_ALL_RED = 3'd0;
  localparam logic [2:0] S_WALK    = 3'd1;
  localparam logic [2:0] S_GREEN   = 3'd2;
  localparam logic [2:0] S_EXT     = 3'd3;
  localparam logic [2:0] S_YELLOW  = 3'd4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] sensor = '0;
  logic [3:0] walk_req = '0;
  logic [7:0] t_green_min = 8'd3;
  logic [7:0] t_green_ext = 8'd2;
  logic [7:0] t_yellow = 8'd2;
  logic [7:0] t_allred = 8'd1;
  logic [7:0] t_walk = 8'd2;
  logic       preempt = 1'b0;
  logic [1:0] preempt_ph = '0;
  logic [3:0] green, yellow, red, walk;
  logic [1:0] cur_phase;
  logic [2:0] state;

  int passed = 0;
  int total  = 0;
  int n;
  logic bad;

  multi_phase_traffic_controller #(
    .NUM_PHASES (4),
    .TIMER_W    (8),
    .TICK_DIV   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sensor      (sensor),
    .walk_req    (walk_req),
    .t_green_min (t_green_min),
    .t_green_ext (t_green_ext),
    .t_yellow    (t_yellow),
    .t_allred    (t_allred),
    .t_walk      (t_walk),
    .preempt     (preempt),
    .preempt_ph  (preempt_ph),
    .green       (green),
    .yellow      (yellow),
    .red         (red),
    .walk        (walk),
    .cur_phase   (cur_phase),
    .state       (state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Cycles until state leaves its current value (called at state entry)
  task automatic measure(output int cyc);
    logic [2:0] s;
    s = state;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while ((state === s) && (cyc < 400));
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int lim);
    int k;
    k = 0;
    while ((state !== s) && (k < lim)) begin
      @(posedge clk); #1;
      k++;
    end
    check(tag, {29'd0, state}, {29'd0, s});
  endtask

  initial begin
    // Power-on reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_red",   {28'd0, red},   32'hF);
    check("rst_green", {28'd0, green}, 32'h0);
    check("rst_state", {29'd0, state}, {29'd0, S_ALL_RED});
    check("rst_walk",  {28'd0, walk},  32'h0);
    reset = 1'b1;

    // Initial clearance is one tick, then rest green on phase 0
    measure(n);
    check("init_allred_cycles", n, 4);
    check("init_green", {28'd0, green}, 32'h1);

    // No demand: green 0 held, never yellow, no walk
    bad = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if ((state !== S_GREEN) || (yellow !== 4'h0) || (walk !== 4'h0)) bad = 1'b1;
    end
    check("rest_hold", {31'd0, bad}, 32'd0);

    // Asynchronous reset mid-green
    #3 reset = 1'b0;
    #1;
    check("async_red",   {28'd0, red},       32'hF);
    check("async_green", {28'd0, green},     32'h0);
    check("async_state", {29'd0, state},     {29'd0, S_ALL_RED});
    check("async_cur",   {30'd0, cur_phase}, 32'd0);

    // Demand on phase 2 only: phases 1 and 3 skipped
    sensor = 4'b0100;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    measure(n);
    check("p2_allred0", n, 4);
    measure(n);
    check("p2_green0_cycles", n, 12);
    check("p2_yellow0", {28'd0, yellow}, 32'h1);
    check("p2_red_y", {28'd0, red}, 32'hE);
    measure(n);
    check("p2_yellow_cycles", n, 8);
    check("p2_allred_red", {28'd0, red}, 32'hF);
    measure(n);
    check("p2_allred_cycles", n, 4);
    check("p2_cur", {30'd0, cur_phase}, 32'd2);
    check("p2_green2", {28'd0, green}, 32'h4);
    check("p2_red_g", {28'd0, red}, 32'hB);

    // Sensor held: single extension, then yellow
    measure(n);
    check("ext_base_cycles", n, 12);
    check("ext_state", {29'd0, state}, {29'd0, S_EXT});
    check("ext_green", {28'd0, green}, 32'h4);
    measure(n);
    check("ext_cycles", n, 8);
    check("ext_then_yellow", {28'd0, yellow}, 32'h4);
    measure(n);
    measure(n);
    check("back_to_0", {30'd0, cur_phase}, 32'd0);
    check("back_green0", {28'd0, green}, 32'h1);

    // Walk request pulse on phase 1 during green 0
    sensor   = 4'b0000;
    walk_req = 4'b0010;
    @(posedge clk); #1;
    walk_req = 4'b0000;
    measure(n);
    check("wk_green0_rest", n, 11);
    check("wk_yellow", {29'd0, state}, {29'd0, S_YELLOW});
    measure(n);
    measure(n);
    check("wk_state", {29'd0, state}, {29'd0, S_WALK});
    check("wk_lamp", {28'd0, walk}, 32'h2);
    check("wk_red", {28'd0, red}, 32'hF);
    measure(n);
    check("wk_cycles", n, 8);
    check("wk_green1", {28'd0, green}, 32'h2);
    check("wk_off", {28'd0, walk}, 32'h0);

    // Preempt request for phase 3 during green 1
    preempt    = 1'b1;
    preempt_ph = 2'd3;
`ifdef PREEMPT_EN
    measure(n);
    check("pre_to_yellow", n, 1);
    check("pre_yellow1", {28'd0, yellow}, 32'h2);
    measure(n);
    check("pre_yellow_cycles", n, 7);
    measure(n);
    check("pre_cur3", {30'd0, cur_phase}, 32'd3);
    bad = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if ((state !== S_GREEN) || (green !== 4'h8)) bad = 1'b1;
    end
    check("pre_hold", {31'd0, bad}, 32'd0);
    preempt = 1'b0;
    wait_state("pre_release_yellow", S_YELLOW, 100);
    wait_state("pre_back_green", S_GREEN, 100);
    check("pre_back_cur0", {30'd0, cur_phase}, 32'd0);
`else
    measure(n);
    check("nopre_green1_cycles", n, 12);
    check("nopre_yellow1", {28'd0, yellow}, 32'h2);
    measure(n);
    check("nopre_yellow_cycles", n, 8);
    measure(n);
    check("nopre_cur0", {30'd0, cur_phase}, 32'd0);
    preempt = 1'b0;
`endif

    // Zero timing values act as one tick; zero extension means none
    sensor      = 4'b0010;
    t_yellow    = 8'd0;
    t_green_ext = 8'd0;
    wait_state("zero_reach_yellow", S_YELLOW, 100);
    measure(n);
    check("zero_yellow_cycles", n, 4);
    measure(n);
    check("zero_cur1", {30'd0, cur_phase}, 32'd1);
    measure(n);
    check("noext_green_cycles", n, 12);
    check("noext_yellow", {29'd0, state}, {29'd0, S_YELLOW});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
